// File: rtl/bitvec_serializer_if.sv
// Valid/ready bundle for bitvec_serializer: parallel word in, serial bits out.
interface bitvec_serializer_if #(
    parameter int WIDTH = 6
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_bit;
    logic             out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_bit, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_bit, out_last
    );
endinterface

// File: rtl/bitvec_serializer.sv
// Parallel-to-serial stage: one WIDTH-bit word per handshake, one bit per beat.
// Define SERIALIZER_PARITY_EN to append an even-parity beat after the data.
module bitvec_serializer #(
    parameter int WIDTH     = 6,
    parameter int MSB_FIRST = 0,
    parameter int WCNT_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    bitvec_serializer_if.slave bus,
    output logic              busy,
    output logic [WCNT_W-1:0] word_cnt
);
`ifdef SERIALIZER_PARITY_EN
    localparam int NBEATS = WIDTH + 1;
`else
    localparam int NBEATS = WIDTH;
`endif
    localparam int CW = (NBEATS < 2) ? 1 : $clog2(NBEATS);
    localparam logic [CW-1:0] LASTB = CW'(NBEATS - 1);

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    state_t            r_state;
    logic [WIDTH-1:0]  r_sh;
    logic [CW-1:0]     r_cnt;
    logic [WCNT_W-1:0] r_wcnt;
    logic              w_xfer;
    logic              w_last;
    logic              w_dbit;
    logic              w_bit;
`ifdef SERIALIZER_PARITY_EN
    logic              r_par;
`endif

    assign w_dbit = (MSB_FIRST != 0) ? r_sh[WIDTH-1] : r_sh[0];
`ifdef SERIALIZER_PARITY_EN
    // Data register has drained to zero by the time the parity beat is up.
    assign w_bit = (r_cnt == CW'(WIDTH)) ? r_par : w_dbit;
`else
    assign w_bit = w_dbit;
`endif

    assign w_last        = (r_state == S_SHIFT) && (r_cnt == LASTB);
    assign w_xfer        = bus.out_valid && bus.out_ready;
    assign bus.in_ready  = rst_n && (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_SHIFT);
    assign bus.out_bit   = (r_state == S_SHIFT) ? w_bit : 1'b0;
    assign bus.out_last  = w_last;
    assign busy          = (r_state == S_SHIFT);
    assign word_cnt      = r_wcnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_sh    <= '0;
            r_cnt   <= '0;
            r_wcnt  <= '0;
`ifdef SERIALIZER_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.in_valid && bus.in_ready) begin
                        r_sh    <= bus.in_data;
                        r_cnt   <= '0;
                        r_state <= S_SHIFT;
`ifdef SERIALIZER_PARITY_EN
                        r_par   <= ^bus.in_data;
`endif
                    end
                end
                S_SHIFT: begin
                    if (w_xfer) begin
                        r_sh <= (MSB_FIRST != 0) ? (r_sh << 1) : (r_sh >> 1);
                        if (w_last) begin
                            r_cnt   <= '0;
                            r_wcnt  <= r_wcnt + 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
